// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// UART_TX_ARBITER_PARITY_EN selects an 11-bit frame with an even parity bit.
package uart_tx_arb_pkg;

  localparam int unsigned DATA_W = 8;

`ifdef UART_TX_ARBITER_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Byte-to-8N1 serializer: baud counter, bit counter and txd register.
// With UART_TX_ARBITER_PARITY_EN an even parity bit precedes the stop bit.
module uart_tx_serializer
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_byte,
  output logic              o_busy,
  output logic              o_txd
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e         r_state, w_state_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic [2:0]        r_bit, w_bit_n;
  logic [DATA_W-1:0] r_shift, w_shift_n;
  logic              r_txd, w_txd_n;
  logic              r_busy, w_busy_n;
`ifdef UART_TX_ARBITER_PARITY_EN
  logic              r_par, w_par_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
`ifdef UART_TX_ARBITER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_txd   <= w_txd_n;
      r_busy  <= w_busy_n;
`ifdef UART_TX_ARBITER_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  // Every state lasts CLKS_PER_BIT cycles; txd is updated together with the state.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_txd_n   = r_txd;
    w_busy_n  = r_busy;
`ifdef UART_TX_ARBITER_PARITY_EN
    w_par_n   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        w_txd_n = 1'b1;
        if (i_start) begin
          w_state_n = ST_START;
          w_cnt_n   = CNT_LOAD;
          w_shift_n = i_byte;
          w_txd_n   = 1'b0;
          w_busy_n  = 1'b1;
`ifdef UART_TX_ARBITER_PARITY_EN
          w_par_n   = ^i_byte;
`endif
        end
      end
      ST_START: begin
        if (r_cnt == '0) begin
          w_state_n = ST_DATA;
          w_cnt_n   = CNT_LOAD;
          w_bit_n   = '0;
          w_txd_n   = r_shift[0];
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_n = CNT_LOAD;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_ARBITER_PARITY_EN
            w_state_n = ST_PARITY;
            w_txd_n   = r_par;
`else
            w_state_n = ST_STOP;
            w_txd_n   = 1'b1;
`endif
          end else begin
            w_bit_n   = r_bit + 3'd1;
            w_shift_n = r_shift >> 1;
            w_txd_n   = r_shift[1];
          end
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
`ifdef UART_TX_ARBITER_PARITY_EN
      ST_PARITY: begin
        if (r_cnt == '0) begin
          w_state_n = ST_STOP;
          w_cnt_n   = CNT_LOAD;
          w_txd_n   = 1'b1;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (r_cnt == '0) begin
          w_state_n = ST_IDLE;
          w_txd_n   = 1'b1;
          w_busy_n  = 1'b0;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_txd_n   = 1'b1;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  assign o_busy = r_busy;
  assign o_txd  = r_txd;

  a_cpb_legal: assert property (@(posedge clk) disable iff (rst) (CLKS_PER_BIT >= 2));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-requester lock sharing one UART transmit pin.
// Frame format follows UART_TX_ARBITER_PARITY_EN (8N1, or 8E1 when defined).
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                      io_mainClk,
  input  logic                      io_asyncReset,
  input  logic [NUM_REQ-1:0]        io_req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] io_req_data,
  input  logic [NUM_REQ-1:0]        io_req_lock,
  output logic [NUM_REQ-1:0]        io_req_ready,
  output logic [NUM_REQ-1:0]        io_grant,
  output logic                      io_busy,
  output logic                      io_uart_txd
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]  r_ptr, w_ptr_n;
  logic [IDX_W-1:0]  r_owner, w_owner_n;
  logic              r_lock, w_lock_n;
  logic [IDX_W-1:0]  w_sel, w_idx;
  logic              w_found, w_xfer, w_ser_busy;
  logic [DATA_W-1:0] w_bytes [NUM_REQ];
  logic [DATA_W-1:0] w_byte;

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_ptr   <= LAST_IDX;
      r_owner <= '0;
      r_lock  <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_n;
      r_owner <= w_owner_n;
      r_lock  <= w_lock_n;
    end
  end

  // A held lock restricts eligibility to the owner; otherwise search from last owner + 1.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_owner;
    w_idx   = '0;
    if (r_lock) begin
      w_found = io_req_valid[r_owner];
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        w_idx = IDX_W'((32'(r_ptr) + i + 32'd1) % NUM_REQ);
        if (!w_found && io_req_valid[w_idx]) begin
          w_found = 1'b1;
          w_sel   = w_idx;
        end
      end
    end
  end

  assign w_xfer = w_found & ~w_ser_busy;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_bytes[i] = io_req_data[i*DATA_W +: DATA_W];
    end
    w_byte = w_bytes[w_sel];
  end

  always_comb begin
    w_ptr_n   = r_ptr;
    w_owner_n = r_owner;
    w_lock_n  = r_lock;
    if (w_xfer) begin
      w_ptr_n   = w_sel;
      w_owner_n = w_sel;
      w_lock_n  = io_req_lock[w_sel];
    end else if (!w_ser_busy && r_lock && !io_req_lock[r_owner]) begin
      w_lock_n  = 1'b0;
    end
  end

  always_comb begin
    io_req_ready = '0;
    io_grant     = '0;
    if (w_xfer) io_req_ready[w_sel] = 1'b1;
    if (w_ser_busy || r_lock) io_grant[r_owner] = 1'b1;
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk    (io_mainClk),
    .rst    (io_asyncReset),
    .i_start(w_xfer),
    .i_byte (w_byte),
    .o_busy (w_ser_busy),
    .o_txd  (io_uart_txd)
  );

  assign io_busy = w_ser_busy;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single board UART transmit pin between NUM_REQ byte-stream requesters, e.g. the Murax SoC console and a board-level self-test/status reporter. The block arbitrates round-robin with an optional per-requester lock, so multi-byte messages are not interleaved. It serializes the granted byte as 8N1 onto io_uart_txd. It sits in the board toplevel between the requesters and the pin.

Parameters:
NUM_REQ, 2, number of requesters (1..8).
CLKS_PER_BIT, 868, io_mainClk cycles per UART bit (100 MHz / 115200). Values < 2 are illegal; a simulation assertion flags them.

Ports:
io_mainClk  input  1  system clock.
io_asyncReset  input  1  reset, asynchronous, active-high.
io_req_valid  input  NUM_REQ  per-requester byte valid.
io_req_data  input  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
io_req_lock  input  NUM_REQ  requester i holds the grant after its current byte.
io_req_ready  output  NUM_REQ  byte accepted this cycle (valid & ready = transfer).
io_grant  output  NUM_REQ  one-hot current owner; 0 when idle and unlocked.
io_busy  output  1  frame in progress.
io_uart_txd  output  1  serial line, idles high.

Behaviour:
- Reset values: io_uart_txd=1, io_req_ready=0, io_grant=0, io_busy=0, state IDLE, lock clear. The round-robin pointer is set so requester 0 has first priority. Reset takes effect asynchronously, so a frame in flight is truncated and txd returns high immediately.
- States: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - Select the eligible requester: if lock is held, only the owner is eligible; otherwise take the first valid requester searching from last_owner+1 modulo NUM_REQ.
  - io_req_ready[sel] is combinational and asserts in IDLE only.
  - On transfer: latch the byte, set owner=sel, lock_reg=io_req_lock[sel], go to START next cycle.
- Lock release: in IDLE, if lock_reg=1 and io_req_lock[owner]=0, clear lock_reg in that cycle. The freed arbitration applies from the next cycle.
- START: txd=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; 3-bit index counter.
- STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
- Cycle budget:
  - The minimum idle-high time between frames is CLKS_PER_BIT+1 cycles (stop plus one IDLE cycle).
  - Byte period is 10*CLKS_PER_BIT+1 cycles.
- Baud counter: loads CLKS_PER_BIT-1 on each state/bit entry and advances at 0. Width is $clog2(CLKS_PER_BIT).
- io_busy=1 in every state except IDLE.
- io_grant = one-hot(owner) while busy or lock_reg=1; else 0.
- Requester contract: once valid is asserted, valid and data stay stable until ready. A valid drop without transfer is tolerated; nothing is sent.
- Simultaneous valid from all requesters with no lock: grants rotate strictly.

Optional Feature:
UART_TX_ARBITER_PARITY_EN:
- Defined: a PARITY state is inserted between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 11-bit frame.
- Undefined: the PARITY state and its logic are absent, giving an 8N1 10-bit frame.

Decomposition:
- Package uart_tx_arb_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_W=8;
  - FRAME_BITS (10, or 11 with parity).
- Sub-module uart_tx_serializer: baud counter, bit counter, state FSM and txd register, with a start/byte/busy handshake.
- The top-level block holds the arbiter (pointer, owner, lock_reg) and the ready/grant logic.

Test Plan:
- Reset then req0 sends 0x55 (CLKS_PER_BIT=4):
  - txd = 1 during reset;
  - then 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles;
  - io_busy high for exactly 40 cycles; ready0 one cycle.
- Both requesters valid continuously, locks low, req0=0xA0, req1=0x0B: frames alternate 0xA0, 0x0B, 0xA0, 0x0B; io_grant alternates 01, 10.
- req0 lock high for 3 bytes then low, req1 valid throughout:
  - three consecutive req0 frames, then the req1 frame;
  - io_grant=01 held across the inter-frame IDLE cycles.
- io_asyncReset asserted mid DATA bit 3:
  - txd=1 and busy=0 the same cycle;
  - after release, next 0x3C frame is bit-exact.
- PARITY_EN, send 0x07: 11-bit frame with parity bit 1, 44 cycles busy. Send 0x03: parity bit 0.
- Back-to-back req1 bytes: the next START begins exactly CLKS_PER_BIT+1 cycles after the previous STOP begins.
